gemm_tile_sequencer: RTL and testbench

Control FSM that drives the CFU's 4x4 int8 systolic array and its two global-buffer BRAMs (A: 16-bit index, B: 14-bit index) for one GEMM of size MxK by KxN.
It walks output tiles, issues BRAM reads, and generates feed, zero-inject and clear strobes for the PE grid.
It hands the 16 accumulators of each tile to the CFU response path one at a time, under a valid/ready handshake.
It replaces the ad-hoc start_count/get_val_or_cal sequencing inside the CFU top.

---
 rtl/gemm_seq_pkg.sv | 27 ++
 rtl/gemm_tile_sequencer_walker.sv | 101 ++++++++++
 rtl/gemm_tile_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_gemm_tile_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gemm_seq_pkg.sv
//------------------------------------------------------------------------------
// Module  : gemm_seq_pkg
// Brief   : Shared types and constants for the GEMM tile sequencer.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package gemm_seq_pkg;

  // Systolic array edge and the derived per-tile constants.
  localparam int DIM        = 4;
  localparam int FLUSH_LEN  = 2 * (DIM - 1);
  localparam int TILE_ELEMS = DIM * DIM;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_FLUSH = 3'd2,
    ST_DRAIN = 3'd3,
    ST_CLEAR = 3'd4,
    ST_DONE  = 3'd5
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/gemm_tile_sequencer_walker.sv
//------------------------------------------------------------------------------
// Module  : tile_walker
// Brief   : Tile/k counters and BRAM address generation for the GEMM
//           sequencer. Tile base addresses advance by K with adders, so no
//           multiplier is needed for mt*K or nt*K.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tile_walker #(
  parameter int DIM      = 4,
  parameter int A_ADDR_W = 16,
  parameter int B_ADDR_W = 14,
  parameter int SZ_W     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                step_k,
  input  logic                next_tile,
  input  logic [SZ_W-1:0]     size_m,
  input  logic [SZ_W-1:0]     size_n,
  input  logic [SZ_W-1:0]     size_k,
  input  logic [A_ADDR_W-1:0] a_base,
  input  logic [B_ADDR_W-1:0] b_base,
  output logic [A_ADDR_W-1:0] a_addr,
  output logic [B_ADDR_W-1:0] b_addr,
  output logic                k_last,
  output logic                tile_last
);

  logic [SZ_W-1:0]     r_k;
  logic [SZ_W-1:0]     r_k_max;
  logic [SZ_W-1:0]     r_mt;
  logic [SZ_W-1:0]     r_nt;
  logic [SZ_W-1:0]     r_mt_max;
  logic [SZ_W-1:0]     r_nt_max;
  logic [A_ADDR_W-1:0] r_a_tile;
  logic [B_ADDR_W-1:0] r_b_tile;
  logic [B_ADDR_W-1:0] r_b_base;
  logic [A_ADDR_W-1:0] r_a_step;
  logic [B_ADDR_W-1:0] r_b_step;

  logic                w_nt_last;
  logic                w_mt_last;

  assign k_last    = (r_k == r_k_max);
  assign w_nt_last = (r_nt == r_nt_max);
  assign w_mt_last = (r_mt == r_mt_max);
  assign tile_last = w_mt_last && w_nt_last;

  // Word address = tile base + k, wrapping modulo the BRAM index width.
  assign a_addr = r_a_tile + A_ADDR_W'(r_k);
  assign b_addr = r_b_tile + B_ADDR_W'(r_k);

  // Latch the job on load; step k during fetch; move to the next tile (nt inner, mt outer).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k      <= '0;
      r_k_max  <= '0;
      r_mt     <= '0;
      r_nt     <= '0;
      r_mt_max <= '0;
      r_nt_max <= '0;
      r_a_tile <= '0;
      r_b_tile <= '0;
      r_b_base <= '0;
      r_a_step <= '0;
      r_b_step <= '0;
    end else if (load) begin
      // Sizes are known nonzero here, so the "-1" forms never underflow.
      r_k      <= '0;
      r_mt     <= '0;
      r_nt     <= '0;
      r_k_max  <= size_k - SZ_W'(1);
      r_mt_max <= (size_m - SZ_W'(1)) / SZ_W'(DIM);
      r_nt_max <= (size_n - SZ_W'(1)) / SZ_W'(DIM);
      r_a_tile <= a_base;
      r_b_tile <= b_base;
      r_b_base <= b_base;
      r_a_step <= A_ADDR_W'(size_k);
      r_b_step <= B_ADDR_W'(size_k);
    end else if (next_tile) begin
      r_k <= '0;
      if (w_nt_last) begin
        r_nt     <= '0;
        r_b_tile <= r_b_base;
        r_mt     <= r_mt + SZ_W'(1);
        r_a_tile <= r_a_tile + r_a_step;
      end else begin
        r_nt     <= r_nt + SZ_W'(1);
        r_b_tile <= r_b_tile + r_b_step;
      end
    end else if (step_k) begin
      r_k <= k_last ? '0 : (r_k + SZ_W'(1));
    end
  end

endmodule

`default_nettype wire

// File: rtl/gemm_tile_sequencer.sv
//------------------------------------------------------------------------------
// Module  : gemm_tile_sequencer
// Brief   : Control FSM for the 4x4 int8 systolic array: walks output tiles,
//           issues A/B BRAM reads, drives feed/zero/clear strobes and hands the
//           tile accumulators out one at a time over valid/ready.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module gemm_tile_sequencer
  import gemm_seq_pkg::*;
#(
  parameter int DIM      = 4,
  parameter int A_ADDR_W = 16,
  parameter int B_ADDR_W = 14,
  parameter int SZ_W     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [SZ_W-1:0]     size_m,
  input  logic [SZ_W-1:0]     size_n,
  input  logic [SZ_W-1:0]     size_k,
  input  logic [A_ADDR_W-1:0] a_base,
  input  logic [B_ADDR_W-1:0] b_base,
  input  logic                abort,
  output logic                a_rd_en,
  output logic [A_ADDR_W-1:0] a_rd_addr,
  output logic                b_rd_en,
  output logic [B_ADDR_W-1:0] b_rd_addr,
  output logic                pe_feed,
  output logic                pe_zero,
  output logic                pe_clear,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [3:0]          out_idx,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int C_FLUSH_LEN  = 2 * (DIM - 1);
  localparam int C_TILE_ELEMS = DIM * DIM;
  localparam int C_FC_W       = $clog2(C_FLUSH_LEN + 1);

  seq_state_t          r_state;
  seq_state_t          w_state_nxt;

  logic [C_FC_W-1:0]   r_flush_cnt;
  logic [3:0]          r_drain_cnt;
  logic                r_pe_feed;
  logic                r_pe_zero;
  logic                r_err;
  logic                r_aborting;

  logic                w_size_ok;
  logic                w_abort;
  logic                w_load;
  logic                w_step_k;
  logic                w_next_tile;
  logic                w_k_last;
  logic                w_tile_last;
  logic [A_ADDR_W-1:0] w_a_addr;
  logic [B_ADDR_W-1:0] w_b_addr;

  assign w_size_ok   = (|size_m) && (|size_n) && (|size_k);
  assign w_abort     = abort && (r_state != ST_IDLE);
  assign w_load      = (r_state == ST_IDLE) && start && w_size_ok;
  assign w_step_k    = (r_state == ST_FETCH);
  assign w_next_tile = (r_state == ST_CLEAR) && !r_aborting && !abort && !w_tile_last;

  tile_walker #(
    .DIM      (DIM),
    .A_ADDR_W (A_ADDR_W),
    .B_ADDR_W (B_ADDR_W),
    .SZ_W     (SZ_W)
  ) u_walker (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (w_load),
    .step_k    (w_step_k),
    .next_tile (w_next_tile),
    .size_m    (size_m),
    .size_n    (size_n),
    .size_k    (size_k),
    .a_base    (a_base),
    .b_base    (b_base),
    .a_addr    (w_a_addr),
    .b_addr    (w_b_addr),
    .k_last    (w_k_last),
    .tile_last (w_tile_last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; abort overrides every other transition outside IDLE.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (start) w_state_nxt = w_size_ok ? ST_FETCH : ST_DONE;
      ST_FETCH: if (w_k_last) w_state_nxt = ST_FLUSH;
      ST_FLUSH: if (r_flush_cnt == C_FC_W'(C_FLUSH_LEN - 1)) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (out_ready && (r_drain_cnt == 4'(C_TILE_ELEMS - 1))) w_state_nxt = ST_CLEAR;
      ST_CLEAR: begin
        if (r_aborting)       w_state_nxt = ST_IDLE;
        else if (w_tile_last) w_state_nxt = ST_DONE;
        else                  w_state_nxt = ST_FETCH;
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (w_abort) w_state_nxt = ST_CLEAR;
  end

  // State-decoded outputs; addresses are forced to zero outside FETCH.
  always_comb begin
    a_rd_en   = 1'b0;
    b_rd_en   = 1'b0;
    a_rd_addr = '0;
    b_rd_addr = '0;
    pe_clear  = 1'b0;
    out_valid = 1'b0;
    out_idx   = '0;
    done      = 1'b0;
    busy      = (r_state != ST_IDLE);
    unique case (r_state)
      ST_FETCH: begin
        a_rd_en   = 1'b1;
        b_rd_en   = 1'b1;
        a_rd_addr = w_a_addr;
        b_rd_addr = w_b_addr;
      end
      ST_DRAIN: begin
        out_valid = 1'b1;
        out_idx   = r_drain_cnt;
      end
      ST_CLEAR: pe_clear = 1'b1;
      ST_DONE:  done     = 1'b1;
      default:  ;
    endcase
  end

  assign pe_feed = r_pe_feed;
  assign pe_zero = r_pe_zero;
  assign err     = r_err;

  // Feed/zero lag the state by one cycle to line up with the 1-cycle BRAM read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pe_feed <= 1'b0;
      r_pe_zero <= 1'b0;
    end else begin
      r_pe_feed <= ((r_state == ST_FETCH) || (r_state == ST_FLUSH)) && !w_abort;
      r_pe_zero <= (r_state == ST_FLUSH) && !w_abort;
    end
  end

  // Flush length and drain index counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flush_cnt <= '0;
      r_drain_cnt <= '0;
    end else begin
      r_flush_cnt <= (r_state == ST_FLUSH) ? (r_flush_cnt + C_FC_W'(1)) : '0;
      if (r_state == ST_CLEAR)
        r_drain_cnt <= '0;
      else if ((r_state == ST_DRAIN) && out_ready)
        r_drain_cnt <= r_drain_cnt + 4'd1;
    end
  end

  // Sticky error and abort-in-progress flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err      <= 1'b0;
      r_aborting <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && start) r_err <= !w_size_ok;
      else if (w_abort)                  r_err <= 1'b1;

      if (r_state == ST_IDLE) r_aborting <= 1'b0;
      else if (w_abort)       r_aborting <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gemm_tile_sequencer.sv
//------------------------------------------------------------------------------
// Module  : tb_gemm_tile_sequencer
// Brief   : Self-checking bench for gemm_tile_sequencer.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_gemm_tile_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] size_m;
  logic [15:0] size_n;
  logic [15:0] size_k;
  logic [15:0] a_base;
  logic [13:0] b_base;
  logic        abort;
  logic        a_rd_en;
  logic [15:0] a_rd_addr;
  logic        b_rd_en;
  logic [13:0] b_rd_addr;
  logic        pe_feed;
  logic        pe_zero;
  logic        pe_clear;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_idx;
  logic        busy;
  logic        done;
  logic        err;

  gemm_tile_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .size_m    (size_m),
    .size_n    (size_n),
    .size_k    (size_k),
    .a_base    (a_base),
    .b_base    (b_base),
    .abort     (abort),
    .a_rd_en   (a_rd_en),
    .a_rd_addr (a_rd_addr),
    .b_rd_en   (b_rd_en),
    .b_rd_addr (b_rd_addr),
    .pe_feed   (pe_feed),
    .pe_zero   (pe_zero),
    .pe_clear  (pe_clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        a_en;
    logic [15:0] a_addr;
    logic        b_en;
    logic [13:0] b_addr;
    logic        feed;
    logic        zero;
    logic        clear;
    logic        valid;
    logic [3:0]  idx;
    logic        busy;
    logic        done;
    logic        err;
  } obs_t;

  typedef struct {
    logic start;
    logic ready;
    obs_t exp;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] qa[$];
  logic [13:0] qb[$];
  logic [3:0]  qidx[$];
  int          n_done;
  int          n_viol;
  bit          saw_done;

  vec_t vecs[29];

  function automatic obs_t sample_obs();
    obs_t o;
    o.a_en   = a_rd_en;
    o.a_addr = a_rd_addr;
    o.b_en   = b_rd_en;
    o.b_addr = b_rd_addr;
    o.feed   = pe_feed;
    o.zero   = pe_zero;
    o.clear  = pe_clear;
    o.valid  = out_valid;
    o.idx    = out_idx;
    o.busy   = busy;
    o.done   = done;
    o.err    = err;
    return o;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic rdy(input int mode, input int c);
    if (mode == 0) return 1'b1;
    case (c % 4)
      0:       return 1'b1;
      1:       return 1'b0;
      2:       return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  // Launch one job and collect reads, accepted indices and done pulses.
  task automatic run_job(input string tag, input logic [15:0] m, input logic [15:0] n,
                         input logic [15:0] k, input logic [15:0] ab, input logic [13:0] bb,
                         input int ready_mode, input int glitch_cyc);
    logic       p_wait;
    logic [3:0] p_idx;
    qa.delete();
    qb.delete();
    qidx.delete();
    n_done   = 0;
    n_viol   = 0;
    saw_done = 1'b0;
    p_wait   = 1'b0;
    p_idx    = '0;
    @(posedge clk); #1;
    size_m = m; size_n = n; size_k = k; a_base = ab; b_base = bb;
    start = 1'b1;
    out_ready = rdy(ready_mode, 0);
    for (int c = 0; c < 400 && !saw_done; c++) begin
      @(negedge clk);
      if (a_rd_en) qa.push_back(a_rd_addr);
      if (b_rd_en) qb.push_back(b_rd_addr);
      if (p_wait && (!out_valid || out_idx != p_idx)) n_viol++;
      if (out_valid && out_ready) qidx.push_back(out_idx);
      if (done) begin n_done++; saw_done = 1'b1; end
      p_wait = out_valid && !out_ready;
      p_idx  = out_idx;
      @(posedge clk); #1;
      start = (c + 1 == glitch_cyc);
      if (start) begin size_k = 16'd1; size_m = 16'd16; end
      out_ready = rdy(ready_mode, c + 1);
    end
    start = 1'b0;
    out_ready = 1'b1;
    check({tag, "_done_seen"}, 64'(saw_done), 64'd1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done) n_done++;
      @(posedge clk); #1;
    end
    check({tag, "_done_count"}, 64'(n_done), 64'd1);
  endtask

  task automatic check_idx_seq(input string tag, input int total);
    check({tag, "_n_out"}, 64'(qidx.size()), 64'(total));
    for (int i = 0; i < qidx.size(); i++)
      if (qidx[i] !== 4'(i % 16)) begin
        check($sformatf("%s_idx%0d", tag, i), 64'(qidx[i]), 64'(i % 16));
      end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t o;
    obs_t z;
    int   dones;
    int   clear_seen;

    z = '0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    size_m = '0; size_n = '0; size_k = '0; a_base = '0; b_base = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 64'(sample_obs()), 64'(z));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single tile M=N=K... expected waveform, hand-derived per cycle.
    for (int c = 0; c < 29; c++) begin
      vecs[c].start = (c == 0);
      vecs[c].ready = 1'b1;
      vecs[c].exp   = '0;
      if (c >= 1 && c <= 3) begin
        vecs[c].exp.a_en   = 1'b1;
        vecs[c].exp.b_en   = 1'b1;
        vecs[c].exp.a_addr = 16'(c - 1);
        vecs[c].exp.b_addr = 14'(c - 1);
      end
      vecs[c].exp.feed  = (c >= 2 && c <= 10);
      vecs[c].exp.zero  = (c >= 5 && c <= 10);
      vecs[c].exp.valid = (c >= 10 && c <= 25);
      if (c >= 10 && c <= 25) vecs[c].exp.idx = 4'(c - 10);
      vecs[c].exp.clear = (c == 26);
      vecs[c].exp.done  = (c == 27);
      vecs[c].exp.busy  = (c >= 1 && c <= 27);
    end

    @(posedge clk); #1;
    size_m = 16'd4; size_n = 16'd4; size_k = 16'd3; a_base = '0; b_base = '0;
    for (int c = 0; c < 29; c++) begin
      start     = vecs[c].start;
      out_ready = vecs[c].ready;
      @(negedge clk);
      o = sample_obs();
      check($sformatf("t1_cyc%0d", c), 64'(o), 64'(vecs[c].exp));
      @(posedge clk); #1;
    end
    start = 1'b0;

    // Two tiles down M with nonzero bases.
    run_job("t2", 16'd8, 16'd4, 16'd2, 16'd100, 14'd20, 0, -1);
    check("t2_na", 64'(qa.size()), 64'd4);
    check("t2_nb", 64'(qb.size()), 64'd4);
    if (qa.size() == 4 && qb.size() == 4) begin
      check("t2_a", {qa[0], qa[1], qa[2], qa[3]}, {16'd100, 16'd101, 16'd102, 16'd103});
      check("t2_b", 64'({qb[0], qb[1], qb[2], qb[3]}), 64'({14'd20, 14'd21, 14'd20, 14'd21}));
    end
    check_idx_seq("t2", 32);

    // Ragged edges: 2x2 tiles, K=1.
    run_job("t3", 16'd5, 16'd6, 16'd1, 16'd0, 14'd0, 0, -1);
    check("t3_na", 64'(qa.size()), 64'd4);
    if (qa.size() == 4 && qb.size() == 4) begin
      check("t3_a", {qa[0], qa[1], qa[2], qa[3]}, {16'd0, 16'd0, 16'd1, 16'd1});
      check("t3_b", 64'({qb[0], qb[1], qb[2], qb[3]}), 64'({14'd0, 14'd1, 14'd0, 14'd1}));
    end
    check_idx_seq("t3", 64);

    // Back-pressure 1,0,0,1 on out_ready.
    run_job("t4", 16'd4, 16'd4, 16'd1, 16'd0, 14'd0, 1, -1);
    check("t4_hold_violations", 64'(n_viol), 64'd0);
    check_idx_seq("t4", 16);

    // Zero K: error then done next cycle, no reads.
    @(posedge clk); #1;
    size_m = 16'd4; size_n = 16'd4; size_k = 16'd0; start = 1'b1;
    @(negedge clk);
    check("t5_cyc0", 64'(sample_obs()), 64'(z));
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    o = '0; o.done = 1'b1; o.err = 1'b1; o.busy = 1'b1;
    check("t5_cyc1", 64'(sample_obs()), 64'(o));
    @(posedge clk); #1;
    @(negedge clk);
    o = '0; o.err = 1'b1;
    check("t5_cyc2", 64'(sample_obs()), 64'(o));

    // Start during FETCH is ignored; accepted start clears err.
    run_job("t5g", 16'd4, 16'd4, 16'd3, 16'd0, 14'd0, 0, 2);
    check("t5g_na", 64'(qa.size()), 64'd3);
    if (qa.size() == 3)
      check("t5g_a", 64'({qa[0], qa[1], qa[2]}), 64'({16'd0, 16'd1, 16'd2}));
    check_idx_seq("t5g", 16);
    check("t5g_err", 64'(err), 64'd0);

    // Abort during FLUSH (cycle 5).
    @(posedge clk); #1;
    size_m = 16'd4; size_n = 16'd4; size_k = 16'd3;
    dones = 0;
    clear_seen = 0;
    for (int c = 0; c < 10; c++) begin
      start = (c == 0);
      abort = (c == 5);
      @(negedge clk);
      if (done) dones++;
      if (c == 6) check("t6_clear", 64'(pe_clear), 64'd1);
      if (c == 6) check("t6_busy_c6", 64'(busy), 64'd1);
      if (c == 7) check("t6_idle", 64'(busy), 64'd0);
      if (c == 7) check("t6_err", 64'(err), 64'd1);
      if (c >= 7 && pe_clear) clear_seen++;
      @(posedge clk); #1;
    end
    start = 1'b0; abort = 1'b0;
    check("t6_no_done", 64'(dones), 64'd0);
    check("t6_single_clear", 64'(clear_seen), 64'd0);

    // Asynchronous reset mid-DRAIN.
    @(posedge clk); #1;
    for (int c = 0; c < 13; c++) begin
      start = (c == 0);
      @(negedge clk);
      if (c == 12) check("t7_in_drain", 64'({out_valid, out_idx}), 64'({1'b1, 4'd2}));
      if (c < 12) begin @(posedge clk); #1; end
    end
    start = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("t7_reset_outputs", 64'(sample_obs()), 64'(z));
    #4 rst_n = 1'b1;

    // Recovery after reset.
    run_job("t8", 16'd4, 16'd4, 16'd1, 16'd0, 14'd0, 0, -1);
    check_idx_seq("t8", 16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
